uart_rx_fsm: RTL

Frame-sequencing controller for the UART receiver. It drives the enable of the receiver's edge/bit counter and reads back its edge_cnt/bit_cnt. From those counts it issues the enables for the data sampler, deserializer and start/parity/stop checkers. It gathers checker results into a per-frame data_valid and error pulses for the downstream clock-domain logic.

---
 rtl/uart_rx_fsm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer. It drives the bit counter and the checker strobes, then emits registered data_valid and error pulses the cycle after DONE.
// Optional macro UART_RX_BREAK_DET_EN adds break detection: all data bits are 0 and a stop error is seen.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic [CNT_W-1:0] Prescale,
  input  logic [CNT_W-1:0] edge_cnt,
  input  logic [CNT_W-1:0] bit_cnt,
  input  logic             strt_glitch,
  input  logic             par_err,
  input  logic             stp_err,
  output logic             cnt_enable,
  output logic             dat_samp_en,
  output logic             deser_en,
  output logic             strt_chk_en,
  output logic             par_chk_en,
  output logic             stp_chk_en,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

  state_e state, next_state;
  logic   bit_end;
  logic   par_en_q;
  logic   par_err_q;
  logic   stp_err_q;
  logic   brk_hit;

  assign bit_end = (edge_cnt == (Prescale - CNT_W'(1)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (bit_end) next_state = strt_glitch ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == LAST_BIT)) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = DONE;
      DONE:    next_state = RX_IN ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_enable  = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state)
      START: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = bit_end;
      end
      DATA: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = bit_end;
      end
      PARITY: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = bit_end;
      end
      STOP: begin
        cnt_enable  = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = bit_end;
      end
      default: ;
    endcase
  end

  // Frame context is re-armed in DONE as well, so a back-to-back frame starts clean.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else if (state == IDLE || state == DONE) begin
      par_en_q  <= PAR_EN;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      if (par_chk_en) par_err_q <= par_err;
      if (stp_chk_en) stp_err_q <= stp_err;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                all_zero_q <= 1'b1;
    else if (state == IDLE || state == DONE) all_zero_q <= 1'b1;
    else if (deser_en && RX_IN)              all_zero_q <= 1'b0;
  end

  assign brk_hit = all_zero_q && stp_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) break_det <= 1'b0;
    else      break_det <= (state == DONE) && brk_hit;
  end
`else
  assign brk_hit   = 1'b0;
  assign break_det = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= (state == DONE) && !par_err_q && !stp_err_q;
      parity_err <= (state == DONE) && par_err_q;
      frame_err  <= (state == DONE) && stp_err_q && !brk_hit;
    end
  end

endmodule
